tag_cam: RTL and testbench

Parametrised fully-associative tag store with registered lookup and allocate ports. It holds up to ENTRIES tags of TAG_W bits with per-entry valid bits. It answers equality lookups one cycle later with hit flag and index, and allocates new tags with duplicate suppression and round-robin replacement. It sits in front of the cache and TLB data arrays as their tag-match stage, replacing single fixed-width equality checks.

---
 rtl/tag_cam_pkg.sv | 10 +
 rtl/tag_eq.sv | 13 +
 rtl/tag_cam.sv | 158 +++++++++++++++
 tb/tb_tag_cam.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tag_cam_pkg.sv
// tag_cam_pkg: default geometry shared by the tag store and its users.
package tag_cam_pkg;

    // Default tag width in bits.
    localparam int TAG_W_DEF   = 11;

    // Default number of entries (power of two, 2..32).
    localparam int ENTRIES_DEF = 8;

endpackage

// File: rtl/tag_eq.sv
// tag_eq: single-bit equality of two W-bit vectors (per-bit XNOR, AND-reduced).
module tag_eq #(
    parameter int W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);

    // Every bit must agree for the vectors to be equal.
    assign eq = &(a ~^ b);

endmodule

// File: rtl/tag_cam.sv
// tag_cam: fully-associative tag store with registered lookup and allocate ports.
// Lookups report the lowest matching valid entry. Allocates suppress duplicates,
// fill the lowest free slot, and fall back to round-robin replacement when full.
module tag_cam
    import tag_cam_pkg::*;
#(
    parameter  int TAG_W   = TAG_W_DEF,
    parameter  int ENTRIES = ENTRIES_DEF,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit_valid,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    input  logic             alloc_valid,
    input  logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_ack,
    output logic [IDX_W-1:0] alloc_idx,
    output logic             alloc_dup,
    output logic             alloc_evict,
    input  logic             flush
);

    // Index of the lowest set bit; 0 when no bit is set (callers qualify with |vec).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [ENTRIES-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Stored state. Tag contents are never reset; valid bits gate every use.
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ENTRIES-1:0] valid_q;
    logic [IDX_W-1:0]   rr_ptr_q;

    // Raw equality per entry for both ports, before valid qualification.
    logic [ENTRIES-1:0] lk_eq;
    logic [ENTRIES-1:0] al_eq;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_bank
        tag_eq #(.W(TAG_W)) u_lk_eq (
            .a  (tag_q[g]),
            .b  (lookup_tag),
            .eq (lk_eq[g])
        );
        tag_eq #(.W(TAG_W)) u_al_eq (
            .a  (tag_q[g]),
            .b  (alloc_tag),
            .eq (al_eq[g])
        );
    end

    // Only valid entries may match; both ports see pre-write, pre-flush contents.
    logic [ENTRIES-1:0] lk_match;
    logic [ENTRIES-1:0] al_match;
    logic               lk_any;

    assign lk_match = lk_eq & valid_q;
    assign al_match = al_eq & valid_q;
    assign lk_any   = |lk_match;

    // Allocate decision: duplicate first, then lowest free slot, then round-robin victim.
    logic             al_take;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             al_dup_d;
    logic             al_evict_d;
    logic [IDX_W-1:0] al_idx_d;

    // A flush in the same cycle drops the allocate entirely.
    assign al_take = alloc_valid & ~flush;

    // Select the allocate outcome and the entry (if any) to be written.
    always_comb begin
        wr_en      = 1'b0;
        wr_idx     = '0;
        al_dup_d   = 1'b0;
        al_evict_d = 1'b0;
        al_idx_d   = '0;
        if (al_take) begin
            if (|al_match) begin
                al_dup_d = 1'b1;
                al_idx_d = lowest_set(al_match);
            end else if (!(&valid_q)) begin
                wr_en    = 1'b1;
                wr_idx   = lowest_set(~valid_q);
                al_idx_d = wr_idx;
            end else begin
                wr_en      = 1'b1;
                wr_idx     = rr_ptr_q;
                al_evict_d = 1'b1;
                al_idx_d   = rr_ptr_q;
            end
        end
    end

    // Tag array write; no reset needed since valid bits hide stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= alloc_tag;
        end
    end

    // Valid bits and replacement pointer; flush clears both and wins over allocate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            rr_ptr_q <= '0;
        end else if (flush) begin
            valid_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[wr_idx] <= 1'b1;
            end
            if (al_evict_d) begin
                rr_ptr_q <= rr_ptr_q + IDX_W'(1);
            end
        end
    end

    // Lookup result register; fields fall back to 0 when no request was made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_valid <= 1'b0;
            hit       <= 1'b0;
            hit_idx   <= '0;
        end else begin
            hit_valid <= lookup_valid;
            hit       <= lookup_valid & lk_any;
            hit_idx   <= (lookup_valid && lk_any) ? lowest_set(lk_match) : '0;
        end
    end

    // Allocate result register; one-cycle ack pulse, fields 0 when not acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ack   <= 1'b0;
            alloc_idx   <= '0;
            alloc_dup   <= 1'b0;
            alloc_evict <= 1'b0;
        end else begin
            alloc_ack   <= al_take;
            alloc_idx   <= al_idx_d;
            alloc_dup   <= al_dup_d;
            alloc_evict <= al_evict_d;
        end
    end

endmodule

// File: tb/tb_tag_cam.sv
// tb_tag_cam: directed vectors with hand-computed expectations for tag_cam.
module tb_tag_cam;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [10:0] lookup_tag;
    logic        hit_valid;
    logic        hit;
    logic [2:0]  hit_idx;
    logic        alloc_valid;
    logic [10:0] alloc_tag;
    logic        alloc_ack;
    logic [2:0]  alloc_idx;
    logic        alloc_dup;
    logic        alloc_evict;
    logic        flush;

    int vectors;
    int miscompares;

    tag_cam #(.TAG_W(11), .ENTRIES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_tag   (lookup_tag),
        .hit_valid    (hit_valid),
        .hit          (hit),
        .hit_idx      (hit_idx),
        .alloc_valid  (alloc_valid),
        .alloc_tag    (alloc_tag),
        .alloc_ack    (alloc_ack),
        .alloc_idx    (alloc_idx),
        .alloc_dup    (alloc_dup),
        .alloc_evict  (alloc_evict),
        .flush        (flush)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of requests, clock them in, then idle the inputs.
    task automatic applyStimulus(input logic lv, input logic [10:0] lt,
                                 input logic av, input logic [10:0] at,
                                 input logic fl);
        lookup_valid = lv;
        lookup_tag   = lt;
        alloc_valid  = av;
        alloc_tag    = at;
        flush        = fl;
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        lookup_tag   = '0;
        alloc_valid  = 1'b0;
        alloc_tag    = '0;
        flush        = 1'b0;
    endtask

    task automatic checkLookup(input string name, input logic exp_hit, input logic [2:0] exp_idx);
        checkOutput({name, "_hv"},  32'(hit_valid), 32'd1);
        checkOutput({name, "_hit"}, 32'(hit),       32'(exp_hit));
        checkOutput({name, "_idx"}, 32'(hit_idx),   32'(exp_idx));
    endtask

    task automatic checkAlloc(input string name, input logic exp_ack, input logic [2:0] exp_idx,
                              input logic exp_dup, input logic exp_evict);
        checkOutput({name, "_ack"},   32'(alloc_ack),   32'(exp_ack));
        checkOutput({name, "_idx"},   32'(alloc_idx),   32'(exp_idx));
        checkOutput({name, "_dup"},   32'(alloc_dup),   32'(exp_dup));
        checkOutput({name, "_evict"}, 32'(alloc_evict), 32'(exp_evict));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_outs"},
                    32'({hit_valid, hit, hit_idx, alloc_ack, alloc_idx, alloc_dup, alloc_evict}),
                    32'd0);
    endtask

    // Directed sequence following the block's behaviour, one scenario at a time.
    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        lookup_valid = 1'b0;
        lookup_tag   = '0;
        alloc_valid  = 1'b0;
        alloc_tag    = '0;
        flush        = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #3;
        checkAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lookup into an empty store.
        applyStimulus(1'b1, 11'h000, 1'b0, 11'h000, 1'b0);
        checkLookup("empty_lk", 1'b0, 3'd0);
        checkOutput("empty_lk_ack", 32'(alloc_ack), 32'd0);
        applyStimulus(1'b0, 11'h000, 1'b0, 11'h000, 1'b0);
        checkOutput("idle_hv", 32'(hit_valid), 32'd0);

        // Two fresh allocates land in the lowest free slots.
        applyStimulus(1'b0, 11'h000, 1'b1, 11'h2A5, 1'b0);
        checkAlloc("al_2a5", 1'b1, 3'd0, 1'b0, 1'b0);
        checkOutput("al_2a5_hv", 32'(hit_valid), 32'd0);
        applyStimulus(1'b0, 11'h000, 1'b1, 11'h013, 1'b0);
        checkAlloc("al_013", 1'b1, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 11'h013, 1'b0, 11'h000, 1'b0);
        checkLookup("lk_013", 1'b1, 3'd1);
        checkOutput("lk_013_ack", 32'(alloc_ack), 32'd0);

        // Duplicate allocate writes nothing.
        applyStimulus(1'b0, 11'h000, 1'b1, 11'h2A5, 1'b0);
        checkAlloc("dup_2a5", 1'b1, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h2A5, 1'b0, 11'h000, 1'b0);
        checkLookup("lk_2a5", 1'b1, 3'd0);

        // Same-cycle lookup misses a tag being allocated; the next one hits.
        applyStimulus(1'b1, 11'h100, 1'b1, 11'h100, 1'b0);
        checkLookup("same_cyc", 1'b0, 3'd0);
        checkAlloc("al_100", 1'b1, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 11'h100, 1'b0, 11'h000, 1'b0);
        checkLookup("lk_100", 1'b1, 3'd2);

        // Clear the store, then fill all entries.
        applyStimulus(1'b0, 11'h000, 1'b0, 11'h000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 11'h000, 1'b1, 11'(i + 1), 1'b0);
            checkAlloc($sformatf("fill%0d", i), 1'b1, 3'(i), 1'b0, 1'b0);
        end

        // Full store: round-robin replacement from 0 with wrap; victims then miss.
        for (int i = 0; i < 9; i++) begin
            logic [10:0] victim;
            victim = (i < 8) ? 11'(i + 1) : 11'h7FF;
            applyStimulus(1'b0, 11'h000, 1'b1, 11'h7FF - 11'(i), 1'b0);
            checkAlloc($sformatf("evict%0d", i), 1'b1, 3'(i % 8), 1'b0, 1'b1);
            applyStimulus(1'b1, victim, 1'b0, 11'h000, 1'b0);
            checkLookup($sformatf("victim%0d", i), 1'b0, 3'd0);
        end
        applyStimulus(1'b1, 11'h7FE, 1'b0, 11'h000, 1'b0);
        checkLookup("lk_7fe", 1'b1, 3'd1);
        applyStimulus(1'b1, 11'h7F8, 1'b0, 11'h000, 1'b0);
        checkLookup("lk_7f8", 1'b1, 3'd7);

        // Flush beats a simultaneous allocate; lookup still sees pre-flush contents.
        applyStimulus(1'b1, 11'h7F7, 1'b1, 11'h055, 1'b1);
        checkAlloc("flush_al", 1'b0, 3'd0, 1'b0, 1'b0);
        checkLookup("flush_lk", 1'b1, 3'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 11'h7FE - 11'(i), 1'b0, 11'h000, 1'b0);
            checkLookup($sformatf("postflush%0d", i), 1'b0, 3'd0);
        end
        applyStimulus(1'b1, 11'h055, 1'b0, 11'h000, 1'b0);
        checkLookup("lk_055", 1'b0, 3'd0);
        applyStimulus(1'b0, 11'h000, 1'b1, 11'h0AA, 1'b0);
        checkAlloc("al_0aa", 1'b1, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset between edges clears results at once and empties the store.
        applyStimulus(1'b1, 11'h0AA, 1'b1, 11'h123, 1'b0);
        checkLookup("pre_rst", 1'b1, 3'd0);
        checkAlloc("pre_rst_al", 1'b1, 3'd1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("mid_rst");
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 11'h0AA, 1'b0, 11'h000, 1'b0);
        checkLookup("post_rst", 1'b0, 3'd0);
        checkOutput("post_rst_ack", 32'(alloc_ack), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
